// File: rtl/ifid_pipe_buffer_pkg.sv
// ifid_pkg: shared definitions for the IF/ID buffer and the decoder.
//   - Bit positions of the MIPS-style instruction fields.
//   - NOP_INSTR: the all-zero bubble word presented when no entry is valid.
package ifid_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int SH_HI = 10;
  localparam int SH_LO = 6;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/ifid_pipe_buffer_if.sv
// ifid_pipe_buffer_if: fetch-side and decode-side signals of the IF/ID buffer.
//   Fetch side : IFID_Flush, in_valid, in_ready, IFPC_plus4, Instruction
//   Decode side: out_valid, out_ready, OpCode, rs, rt, rd, shamt, Funct,
//                ID_PC_next, count
//   slave  = the buffer itself, master = the surrounding pipeline.
interface ifid_pipe_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);

  logic                       IFID_Flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [XLEN-1:0]            IFPC_plus4;
  logic [31:0]                Instruction;
  logic                       out_valid;
  logic                       out_ready;
  logic [5:0]                 OpCode;
  logic [4:0]                 rs;
  logic [4:0]                 rt;
  logic [4:0]                 rd;
  logic [4:0]                 shamt;
  logic [5:0]                 Funct;
  logic [XLEN-1:0]            ID_PC_next;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  IFID_Flush, in_valid, IFPC_plus4, Instruction, out_ready,
    output in_ready, out_valid, OpCode, rs, rt, rd, shamt, Funct,
           ID_PC_next, count
  );

  modport master (
    output IFID_Flush, in_valid, IFPC_plus4, Instruction, out_ready,
    input  in_ready, out_valid, OpCode, rs, rt, rd, shamt, Funct,
           ID_PC_next, count
  );

endinterface

// File: rtl/ifid_pipe_buffer_ring_mem.sv
// ifid_ring_mem: DEPTH x (32+XLEN) storage for the IF/ID ring.
//   sysclk : write clock
//   we     : write enable, waddr/wdata: synchronous write port
//   raddr  : asynchronous read address, rdata: read data
// Contents are not reset; validity is tracked by the occupancy count in the top.
module ifid_ring_mem
  import ifid_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       sysclk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [32+XLEN-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [32+XLEN-1:0]         rdata
);

  logic [32+XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge sysclk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ifid_pipe_buffer.sv
// ifid_pipe_buffer: DEPTH-entry elastic IF/ID queue with decoded outputs.
//   sysclk, reset : clock, asynchronous active-high reset
//   bus (slave)   : fetch push handshake, decode pop handshake, synchronous
//                   flush, decoded head fields, head PC+4 and occupancy.
// An empty queue presents an all-zero NOP bubble on every field output.
module ifid_pipe_buffer
  import ifid_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic               sysclk,
  input  logic               reset,
  ifid_pipe_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 32 + XLEN;

  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready, out_valid;
  logic            push, pop;
  logic [EW-1:0]   wdata, rdata;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;

  // Status comes only from the registered count, so there is no
  // combinational path from in_valid/out_ready to any output.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = bus.in_valid && in_ready && !bus.IFID_Flush;
  assign pop  = out_valid && bus.out_ready && !bus.IFID_Flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (bus.IFID_Flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  assign wdata = {bus.Instruction, bus.IFPC_plus4};

  ifid_ring_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .sysclk (sysclk),
    .we     (push),
    .waddr  (wp_q),
    .wdata  (wdata),
    .raddr  (rp_q),
    .rdata  (rdata)
  );

  assign head_instr = out_valid ? rdata[EW-1:XLEN] : NOP_INSTR;
  assign head_pc    = out_valid ? rdata[XLEN-1:0]  : '0;

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.count      = count_q;
  assign bus.OpCode     = head_instr[OP_HI:OP_LO];
  assign bus.rs         = head_instr[RS_HI:RS_LO];
  assign bus.rt         = head_instr[RT_HI:RT_LO];
  assign bus.rd         = head_instr[RD_HI:RD_LO];
  assign bus.shamt      = head_instr[SH_HI:SH_LO];
  assign bus.Funct      = head_instr[FN_HI:FN_LO];
  assign bus.ID_PC_next = head_pc;

endmodule

// File: tb/tb_ifid_pipe_buffer.sv
// Bench for ifid_pipe_buffer: one DEPTH=2 and one DEPTH=4 instance share the
// same stimulus; a queue per instance holds the entries expected to be stored.
module tb_ifid_pipe_buffer;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        flush  = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc    = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m2[$];
  logic [63:0] m4[$];

  ifid_pipe_buffer_if #(.XLEN(32), .DEPTH(2)) i2 ();
  ifid_pipe_buffer_if #(.XLEN(32), .DEPTH(4)) i4 ();

  assign i2.IFID_Flush  = flush;
  assign i2.in_valid    = in_valid;
  assign i2.IFPC_plus4  = pc;
  assign i2.Instruction = instr;
  assign i2.out_ready   = out_ready;
  assign i4.IFID_Flush  = flush;
  assign i4.in_valid    = in_valid;
  assign i4.IFPC_plus4  = pc;
  assign i4.Instruction = instr;
  assign i4.out_ready   = out_ready;

  ifid_pipe_buffer #(.XLEN(32), .DEPTH(2)) u_dut2 (
    .sysclk (sysclk), .reset (reset), .bus (i2.slave));
  ifid_pipe_buffer #(.XLEN(32), .DEPTH(4)) u_dut4 (
    .sysclk (sysclk), .reset (reset), .bus (i4.slave));

  wire [63:0] head2 = {i2.OpCode, i2.rs, i2.rt, i2.rd, i2.shamt, i2.Funct, i2.ID_PC_next};
  wire [63:0] head4 = {i4.OpCode, i4.rs, i4.rt, i4.rd, i4.shamt, i4.Funct, i4.ID_PC_next};

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] mhead2();
    return (m2.size() > 0) ? m2[0] : 64'h0;
  endfunction

  function automatic logic [63:0] mhead4();
    return (m4.size() > 0) ? m4[0] : 64'h0;
  endfunction

  // Advance one clock and update both models with the inputs seen at the edge.
  task automatic step();
    bit p2, p4;
    @(posedge sysclk);
    if (reset || flush) begin
      m2.delete();
      m4.delete();
    end else begin
      p2 = in_valid && (m2.size() < 2);
      p4 = in_valid && (m4.size() < 4);
      if (out_ready && m2.size() > 0) void'(m2.pop_front());
      if (out_ready && m4.size() > 0) void'(m4.pop_front());
      if (p2) m2.push_back({instr, pc});
      if (p4) m4.push_back({instr, pc});
    end
    #1;
  endtask

  task automatic drain();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    n_checks++;
    if ({i2.out_valid, i2.in_ready, i2.count} !== {1'b0, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_status: got v/r/cnt %b/%b/%0d expected 0/1/0", i2.out_valid, i2.in_ready, i2.count);
    end
    n_checks++;
    if (head2 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h expected 0", head2);
    end
    reset = 1'b0;
    in_valid = 1'b1; instr = 32'h2108_0001; pc = 32'h0040_0104;
    step();
    instr = 32'h2108_0002; pc = 32'h0040_0108;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (i2.count !== 2'd2) begin
      n_fail++;
      $display("FAIL prefill_count: got %0d expected 2", i2.count);
    end
    #2 reset = 1'b1;
    m2.delete(); m4.delete();
    #1;
    n_checks++;
    if ({i2.out_valid, i2.in_ready, i2.count} !== {1'b0, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL async_reset_status: got v/r/cnt %b/%b/%0d expected 0/1/0", i2.out_valid, i2.in_ready, i2.count);
    end
    n_checks++;
    if (head2 !== 64'h0) begin
      n_fail++;
      $display("FAIL async_reset_fields: got %h expected 0", head2);
    end
    n_checks++;
    if (i4.count !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset_count4: got %0d expected 0", i4.count);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    drain();
    out_ready = 1'b1; in_valid = 1'b1;
    instr = 32'h012A_4020; pc = 32'h0040_0004;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (i2.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_valid: got %b expected 1", i2.out_valid);
    end
    n_checks++;
    if ({i2.OpCode, i2.rs, i2.rt, i2.rd, i2.shamt, i2.Funct} !== {6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20}) begin
      n_fail++;
      $display("FAIL single_fields: got op=%0d rs=%0d rt=%0d rd=%0d sh=%0d fn=%h expected 0/9/10/8/0/20",
               i2.OpCode, i2.rs, i2.rt, i2.rd, i2.shamt, i2.Funct);
    end
    n_checks++;
    if (i2.ID_PC_next !== 32'h0040_0004) begin
      n_fail++;
      $display("FAIL single_pc: got %h expected 00400004", i2.ID_PC_next);
    end
    step();
    n_checks++;
    if (i2.out_valid !== 1'b0 || head2 !== 64'h0) begin
      n_fail++;
      $display("FAIL single_after: got valid=%b head=%h expected 0/0", i2.out_valid, head2);
    end
  endtask

  task automatic test_stall_fill();
    logic [63:0] a, b, c;
    a = {32'h8C01_0004, 32'h0040_0204};
    b = {32'h8C02_0008, 32'h0040_0208};
    c = {32'h8C03_000C, 32'h0040_020C};
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    {instr, pc} = a; step();
    {instr, pc} = b; step();
    n_checks++;
    if (i2.count !== 2'd2 || i2.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_full: got cnt=%0d rdy=%b expected 2/0", i2.count, i2.in_ready);
    end
    {instr, pc} = c; step();
    n_checks++;
    if (i2.count !== 2'd2 || head2 !== a) begin
      n_fail++;
      $display("FAIL stall_hold: got cnt=%0d head=%h expected 2/%h", i2.count, head2, a);
    end
    n_checks++;
    if (i4.count !== 3'(m4.size()) || head4 !== mhead4()) begin
      n_fail++;
      $display("FAIL stall_dut4: got cnt=%0d head=%h expected %0d/%h", i4.count, head4, m4.size(), mhead4());
    end
    out_ready = 1'b1; step();
    n_checks++;
    if (i2.count !== 2'd1 || head2 !== b || i2.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_pop1: got cnt=%0d head=%h rdy=%b expected 1/%h/1", i2.count, head2, i2.in_ready, b);
    end
    step();
    n_checks++;
    if (i2.count !== 2'd1 || head2 !== c) begin
      n_fail++;
      $display("FAIL stall_third: got cnt=%0d head=%h expected 1/%h", i2.count, head2, c);
    end
    in_valid = 1'b0; step();
    n_checks++;
    if (i2.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_empty: got valid=%b expected 0", i2.out_valid);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_list[10];
    logic [63:0] rcv[$];
    int sent = 0;
    int cyc  = 0;
    bit acc;
    for (int i = 0; i < 10; i++) exp_list[i] = {$urandom(), 32'h0040_1000 + 32'(4 * i)};
    drain();
    while ((sent < 10 || m4.size() > 0) && cyc < 200) begin
      in_valid = (sent < 10);
      if (sent < 10) {instr, pc} = exp_list[sent];
      out_ready = (cyc % 2 == 0);
      n_checks++;
      if (i4.count !== 3'(m4.size()) || head4 !== mhead4()) begin
        n_fail++;
        $display("FAIL wrap_state c%0d: got cnt=%0d head=%h expected %0d/%h", cyc, i4.count, head4, m4.size(), mhead4());
      end
      if (i4.out_valid && out_ready) rcv.push_back(head4);
      acc = in_valid && (m4.size() < 4);
      step();
      if (acc) sent++;
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) begin
      n_fail++;
      $display("FAIL wrap_timeout: got %0d cycles expected fewer than 200", cyc);
    end
    n_checks++;
    if (rcv.size() != 10) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d outputs expected 10", rcv.size());
    end
    for (int i = 0; i < 10 && i < rcv.size(); i++) begin
      n_checks++;
      if (rcv[i] !== exp_list[i]) begin
        n_fail++;
        $display("FAIL wrap_order[%0d]: got %h expected %h", i, rcv[i], exp_list[i]);
      end
    end
  endtask

  task automatic test_flush();
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h0022_1820; pc = 32'h0040_0304; step();
    instr = 32'h0022_1822; pc = 32'h0040_0308; step();
    n_checks++;
    if (i2.count !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_pre: got cnt=%0d expected 2", i2.count);
    end
    flush = 1'b1; out_ready = 1'b1;
    instr = 32'hDEAD_BEEF; pc = 32'h0040_0FFC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({i2.out_valid, i2.count} !== 3'b0 || head2 !== 64'h0) begin
      n_fail++;
      $display("FAIL flush_state: got valid=%b cnt=%0d head=%h expected 0/0/0", i2.out_valid, i2.count, head2);
    end
    n_checks++;
    if (i4.count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_dut4: got cnt=%0d expected 0", i4.count);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (i2.out_valid !== 1'b0 || i4.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_dropped: got valid2=%b valid4=%b expected 0/0", i2.out_valid, i4.out_valid);
      end
    end
  endtask

  task automatic test_simul();
    logic [63:0] s1, s2;
    s1 = {32'h3C08_1001, 32'h0040_0404};
    s2 = {32'h3508_0020, 32'h0040_0408};
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    {instr, pc} = s1; step();
    n_checks++;
    if (i2.count !== 2'd1 || head2 !== s1) begin
      n_fail++;
      $display("FAIL simul_pre: got cnt=%0d head=%h expected 1/%h", i2.count, head2, s1);
    end
    {instr, pc} = s2; out_ready = 1'b1; step();
    n_checks++;
    if (i2.count !== 2'd1 || head2 !== s2) begin
      n_fail++;
      $display("FAIL simul_advance: got cnt=%0d head=%h expected 1/%h", i2.count, head2, s2);
    end
    in_valid = 1'b0; step();
    n_checks++;
    if (i2.count !== 2'd0) begin
      n_fail++;
      $display("FAIL simul_end: got cnt=%0d expected 0", i2.count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_fill();
    test_wrap();
    test_flush();
    test_simul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_pipe_buffer.md
# ifid_pipe_buffer

Parametrised IF/ID pipeline buffer. It sits between instruction fetch and decode, replacing the single-entry IF/ID register with a DEPTH-entry elastic queue. The queue uses a valid/ready handshake on both sides, has a synchronous flush, and emits decoded instruction fields with a per-entry valid bit. Fetch can run ahead of a stalled decode stage by up to DEPTH instructions. When the queue is empty, the outputs present an all-zero NOP bubble.

## Interface

Parameters:
- XLEN, 32, width of the PC+4 path.
- DEPTH, 2, number of entries; power of two, ≥ 2.

Ports:
- sysclk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- IFID_Flush  in  1  synchronous flush: discards every entry and any same-cycle push.
- in_valid  in  1  fetch presents an instruction this cycle.
- in_ready  out  1  buffer accepts a push this cycle.
- IFPC_plus4  in  XLEN  PC+4 of the fetched instruction.
- Instruction  in  32  fetched instruction word.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head this cycle (deasserted = decode stall).
- OpCode  out  6  Instruction[31:26] of the head entry.
- rs  out  5  Instruction[25:21] of the head entry.
- rt  out  5  Instruction[20:16] of the head entry.
- rd  out  5  Instruction[15:11] of the head entry.
- shamt  out  5  Instruction[10:6] of the head entry.
- Funct  out  6  Instruction[5:0] of the head entry.
- ID_PC_next  out  XLEN  PC+4 of the head entry.
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation

- Storage is a ring of DEPTH entries, each holding {Instruction, IFPC_plus4}.
  - Write pointer wp and read pointer rp are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is held as a separate register.
- Combinational status:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
- Push fires when in_valid && in_ready && !IFID_Flush.
  - The entry is written at wp and wp increments.
- Pop fires when out_valid && out_ready && !IFID_Flush.
  - rp increments.
- Count update per cycle:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged. This is legal whenever 0 < count < DEPTH.
- When full, in_ready = 0, so no push is accepted even if a pop fires in the same cycle. There is no full-throughput bypass when full.
- Flush:
  - wp, rp and count return to 0 on the next edge.
  - The highest-priority event after reset: it overrides push and pop.
- Output fields:
  - When out_valid = 1, the output fields are slices of the entry at rp.
  - When out_valid = 0, all field outputs and ID_PC_next are forced to 0 (NOP bubble).
- Hold behaviour: when out_ready = 0 and out_valid = 1, every output is stable until a pop or flush.
- Reset (asynchronous, at any time including mid-operation):
  - wp, rp and count go to 0.
  - Storage contents are don't-care.
  - out_valid, count and all field/PC outputs are 0; in_ready is 1.

## Timing

- Latency: an instruction pushed at edge k is visible at the outputs after edge k, i.e. in cycle k+1. There is no same-cycle bypass when empty.
- Sustained throughput: 1 instruction/cycle when 0 < count < DEPTH and both sides handshake.
- in_ready and out_valid depend only on registered count. There are no combinational paths from in_valid or out_ready to any output.
- Flush asserted in cycle k: out_valid = 0 and outputs are NOP from cycle k+1. A push presented in cycle k is dropped.
- Reset deassertion: first push is accepted at the first rising edge with reset low.

## Structure

- Shared package ifid_pkg:
  - field-position localparams (OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SH_HI/LO, FN_HI/LO).
  - NOP_INSTR = 32'h0.
  - Used by the decoder as well.
- One sub-module, ifid_ring_mem:
  - DEPTH × (32+XLEN) register array.
  - Synchronous write port and asynchronous read port.
  - Pointer and count control stay in the top level.

## Test plan

- Reset mid-stream: fill 2 entries, assert reset asynchronously between edges.
  - Immediately: count = 0, out_valid = 0, all fields 0, in_ready = 1.
- Single push, decode ready: push Instruction 0x012A4020 with IFPC_plus4 0x00400004.
  - Next cycle: OpCode = 0, rs = 9, rt = 10, rd = 8, shamt = 0, Funct = 0x20, ID_PC_next = 0x00400004.
  - The cycle after: out_valid = 0.
- Stall fill: out_ready = 0, push 3 instructions into DEPTH = 2.
  - After 2 pushes: in_ready = 0 and count = 2; the 3rd push is held.
  - Outputs stay on the 1st instruction.
  - Release out_ready: order is preserved and the 3rd push is accepted the cycle after the first pop.
- Wrap-around: with DEPTH = 4, stream 10 instructions with out_ready toggling 1,0,1,0….
  - All 10 emerge in order, with no loss or duplication.
- Flush with simultaneous push and pop: count = 2, assert IFID_Flush together with in_valid = 1 and out_ready = 1.
  - Next cycle: count = 0, out_valid = 0, outputs NOP.
  - The flushed-cycle instruction never appears at the outputs.
- Simultaneous push and pop at count = 1:
  - count stays 1 and the head advances to the newly pushed entry.
